// File: rtl/sw_step_conditioner.sv
// Conditions raw switches and a step button for the 3-state Moore FSM: sync, debounce, one strobe per press.
// Optional timed auto-stepping is built when AUTOSTEP_EN is defined.
module sw_step_conditioner #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 5
`ifdef AUTOSTEP_EN
  , parameter int AUTO_PERIOD = 1000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] raw_sw,
  input  logic       raw_btn,
`ifdef AUTOSTEP_EN
  input  logic       auto_en,
`endif
  output logic [1:0] sw_out,
  output logic       step,
  output logic [7:0] step_cnt
);

  typedef enum logic [1:0] {IDLE, FIRE, HOLD} step_state_t;

  step_state_t      state_q, state_d;
  logic [2:0]       sync_q1, sync_q2;
  logic [2:0]       db_q;
  logic [CNT_W-1:0] db_cnt [3];
  logic             db_btn;
  logic             fire_next;
  logic             auto_mode;
  logic             period_hit;

  assign db_btn    = db_q[2];
  assign sw_out    = db_q[1:0];
  assign step      = (state_q == FIRE);
  assign fire_next = (state_d == FIRE);

  // Bit 2 carries the button, bits 1:0 the switches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= {raw_btn, raw_sw};
      sync_q2 <= sync_q1;
    end
  end

  // Switch updates that would land on the edge entering FIRE are held back one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync_q2[i] == db_q[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
          if (i < 2 && fire_next) begin
            db_cnt[i] <= db_cnt[i];
          end else begin
            db_q[i]   <= sync_q2[i];
            db_cnt[i] <= '0;
          end
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef AUTOSTEP_EN
  localparam int AP_W = $clog2(AUTO_PERIOD);

  logic [AP_W-1:0] period_cnt;

  assign auto_mode  = auto_en;
  assign period_hit = (period_cnt == AP_W'(AUTO_PERIOD - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_cnt <= '0;
    end else if (!auto_en || period_hit) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + AP_W'(1);
    end
  end
`else
  assign auto_mode  = 1'b0;
  assign period_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (auto_mode ? period_hit : db_btn) state_d = FIRE;
      end
      FIRE: state_d = HOLD;
      HOLD: begin
        if (auto_mode || !db_btn) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_cnt <= '0;
    end else if (state_q == FIRE) begin
      step_cnt <= step_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_sw_step_conditioner.sv
// Scoreboard bench for sw_step_conditioner: stimulus queues expected step/switch events, a monitor pops them.
// Auto-step checks are included when AUTOSTEP_EN is defined.
module tb_sw_step_conditioner;

  typedef struct {
    int         cyc;
    logic [7:0] cnt;
    logic [1:0] sw;
  } step_exp_t;

  typedef struct {
    int         cyc;
    logic [1:0] sw;
  } sw_exp_t;

  logic       clk;
  logic       reset;
  logic [1:0] raw_sw;
  logic       raw_btn;
`ifdef AUTOSTEP_EN
  logic       auto_en;
`endif
  logic [1:0] sw_out;
  logic       step;
  logic [7:0] step_cnt;

  step_exp_t  step_q[$];
  sw_exp_t    sw_q[$];
  int         tests;
  int         fails;
  int         cyc;
  logic [7:0] exp_cnt;

`ifdef AUTOSTEP_EN
  sw_step_conditioner #(.DB_CYCLES(16), .CNT_W(5), .AUTO_PERIOD(8)) dut (
    .clk(clk), .reset(reset), .raw_sw(raw_sw), .raw_btn(raw_btn), .auto_en(auto_en),
    .sw_out(sw_out), .step(step), .step_cnt(step_cnt)
  );
`else
  sw_step_conditioner #(.DB_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .raw_sw(raw_sw), .raw_btn(raw_btn),
    .sw_out(sw_out), .step(step), .step_cnt(step_cnt)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] sw, input logic btn);
    @(negedge clk);
    raw_sw  = sw;
    raw_btn = btn;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pushStep(input int at_cyc, input logic [1:0] sw);
    step_exp_t e;
    e.cyc = at_cyc;
    e.cnt = exp_cnt;
    e.sw  = sw;
    step_q.push_back(e);
    exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic pushSw(input int at_cyc, input logic [1:0] sw);
    sw_exp_t e;
    e.cyc = at_cyc;
    e.sw  = sw;
    sw_q.push_back(e);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " sw_out"}, int'(sw_out), 0);
    checkOutput({tag, " step"}, int'(step), 0);
    checkOutput({tag, " step_cnt"}, int'(step_cnt), 0);
  endtask

  // Monitor: every step pulse and every sw_out change must match the head of its queue.
  initial begin
    logic [1:0] prev_sw;
    step_exp_t  se;
    sw_exp_t    we;
    prev_sw = 2'b00;
    forever begin
      @(posedge clk);
      #2;
      if (reset === 1'b1) begin
        if (step === 1'b1) begin
          if (step_q.size() == 0) begin
            checkOutput("unexpected step", cyc, -1);
          end else begin
            se = step_q.pop_front();
            checkOutput("step cycle", cyc, se.cyc);
            checkOutput("step_cnt at step", int'(step_cnt), int'(se.cnt));
            checkOutput("sw_out at step", int'(sw_out), int'(se.sw));
          end
        end
        if (sw_out !== prev_sw) begin
          if (sw_q.size() == 0) begin
            checkOutput("unexpected sw_out change", cyc, -1);
          end else begin
            we = sw_q.pop_front();
            checkOutput("sw_out change cycle", cyc, we.cyc);
            checkOutput("sw_out value", int'(sw_out), int'(we.sw));
          end
        end
      end
      prev_sw = sw_out;
    end
  end

  initial begin
    int n;
    int r;
    tests   = 0;
    fails   = 0;
    exp_cnt = 8'd0;
    reset   = 1'b0;
    raw_sw  = 2'b00;
    raw_btn = 1'b0;
`ifdef AUTOSTEP_EN
    auto_en = 1'b0;
`endif
    waitCycles(3);
    checkResetOutputs("reset");
    reset = 1'b1;
    waitCycles(3);

    // Switch debounce: change visible after edge 18.
    applyStimulus(2'b10, 1'b0);
    n = cyc;
    pushSw(n + 18, 2'b10);
    waitCycles(25);

    // Glitch of 10 cycles on the button.
    applyStimulus(2'b10, 1'b1);
    waitCycles(9);
    applyStimulus(2'b10, 1'b0);
    waitCycles(30);
    checkOutput("step_cnt after glitch", int'(step_cnt), 0);

    // Long press with a short dropout, then a clean re-press.
    applyStimulus(2'b10, 1'b1);
    n = cyc;
    pushStep(n + 19, 2'b10);
    waitCycles(99);
    applyStimulus(2'b10, 1'b0);
    waitCycles(7);
    applyStimulus(2'b10, 1'b1);
    waitCycles(99);
    applyStimulus(2'b10, 1'b0);
    waitCycles(29);
    applyStimulus(2'b10, 1'b1);
    n = cyc;
    pushStep(n + 19, 2'b10);
    waitCycles(39);
    applyStimulus(2'b10, 1'b0);
    waitCycles(29);
    checkOutput("step_cnt after two presses", int'(step_cnt), 2);

    // Freeze: switch update falls due on the FIRE edge and slips one cycle.
    applyStimulus(2'b10, 1'b1);
    n = cyc;
    pushStep(n + 19, 2'b10);
    applyStimulus(2'b01, 1'b1);
    pushSw(n + 20, 2'b01);
    waitCycles(38);
    applyStimulus(2'b01, 1'b0);
    waitCycles(29);

    // Reset mid-debounce.
    applyStimulus(2'b01, 1'b1);
    waitCycles(9);
    @(negedge clk);
    reset   = 1'b0;
    raw_btn = 1'b0;
    waitCycles(2);
    checkResetOutputs("reset mid-debounce");
    @(negedge clk);
    reset = 1'b1;
    r = cyc;
    pushSw(r + 18, 2'b01);
    exp_cnt = 8'd0;
    waitCycles(30);

    // Reset mid-HOLD.
    applyStimulus(2'b01, 1'b1);
    n = cyc;
    pushStep(n + 19, 2'b01);
    waitCycles(24);
    @(negedge clk);
    reset   = 1'b0;
    raw_btn = 1'b0;
    waitCycles(2);
    checkResetOutputs("reset mid-hold");
    @(negedge clk);
    reset = 1'b1;
    r = cyc;
    pushSw(r + 18, 2'b01);
    exp_cnt = 8'd0;
    waitCycles(30);

    // Fresh press after reset.
    applyStimulus(2'b01, 1'b1);
    n = cyc;
    pushStep(n + 19, 2'b01);
    waitCycles(24);
    applyStimulus(2'b01, 1'b0);
    waitCycles(24);

    // 256 presses: step_cnt wraps through 255 -> 0.
    for (int k = 0; k < 256; k++) begin
      applyStimulus(2'b01, 1'b1);
      pushStep(cyc + 19, 2'b01);
      waitCycles(23);
      applyStimulus(2'b01, 1'b0);
      waitCycles(23);
    end
    waitCycles(5);
    checkOutput("step_cnt after wrap", int'(step_cnt), int'(exp_cnt));

`ifdef AUTOSTEP_EN
    // Auto-step every 8 cycles for 80 cycles.
    @(negedge clk);
    auto_en = 1'b1;
    n = cyc;
    for (int k = 1; k <= 10; k++) pushStep(n + 8 * k, 2'b01);
    waitCycles(79);
    @(negedge clk);
    auto_en = 1'b0;
    waitCycles(10);
    checkOutput("step_cnt after auto", int'(step_cnt), int'(exp_cnt));
`endif

    waitCycles(5);
    checkOutput("step queue drained", step_q.size(), 0);
    checkOutput("sw queue drained", sw_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
